geofence_n: RTL and testbench

Parametrised convex-geofence evaluator for the sensor-fusion path. It accepts one test point followed by N polygon vertices in arbitrary order over a valid/ready stream. It sorts the vertices by angle around the first vertex using a single shared cross-product datapath, then reports whether the point is inside, on the boundary, or outside. It replaces the fixed 6-vertex, 10-bit, no-handshake fence checker and adds input back-pressure, an on-edge flag and a selectable edge policy.

---
 rtl/geofence_n.sv | 218 +++++++++++++++++++++
 tb/tb_geofence_n.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/geofence_n.sv
`default_nettype none
// ============================================================================
// Module      : geofence_n
// Description : Convex-geofence evaluator. Accepts a test point P followed by
//               N polygon vertices over a valid/ready stream, angle-sorts the
//               vertices around v0 with one shared cross-product datapath,
//               then reports inside / on-edge status for P.
// Ports       : clk        - rising-edge clock
//               reset      - asynchronous active-low reset
//               X, Y       - unsigned coordinate (W bits each)
//               in_valid   - X/Y hold a coordinate
//               in_ready   - coordinate can be accepted
//               valid      - one-cycle result strobe
//               is_inside  - P inside (edge policy from EDGE_INSIDE)
//               on_edge    - P on the polygon boundary
// Revision    : 1.0 - initial release
// ============================================================================
module geofence_n #(
   parameter int W           = 10,
   parameter int N           = 6,
   parameter int EDGE_INSIDE = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] X,
   input  logic [W-1:0] Y,
   input  logic         in_valid,
   output logic         in_ready,
   output logic         valid,
   output logic         is_inside,
   output logic         on_edge
);

   localparam int c_AW = (N > 1) ? $clog2(N) : 1;   // vertex index width
   localparam int c_PW = 2*W + 2;                   // product width

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_LOAD   = 4'd1,
      S_SORT_A = 4'd2,
      S_SORT_B = 4'd3,
      S_SORT_J = 4'd4,
      S_EVAL_A = 4'd5,
      S_EVAL_B = 4'd6,
      S_EVAL_J = 4'd7,
      S_DONE   = 4'd8
   } state_t;

   state_t                  r_state;
   logic [W-1:0]            r_px, r_py;
   logic [W-1:0]            r_vx [N];
   logic [W-1:0]            r_vy [N];
   logic [c_AW-1:0]         r_cnt, r_idx, r_pass;
   logic                    r_neg, r_zero;
   logic                    r_ready, r_valid, r_inside, r_edge;
   logic signed [W:0]       r_da, r_db;
   logic signed [c_PW-1:0]  r_p1;

   logic [c_AW-1:0]         w_j;
   logic                    w_sort;
   logic signed [W:0]       w_da1, w_db1, w_da2, w_db2;
   logic [c_PW-1:0]         w_dae, w_dbe;
   logic signed [c_PW-1:0]  w_prod;
   logic signed [c_PW:0]    w_diff;
   logic                    w_pass_end, w_last_cmp;

   // Full-precision signed difference of two unsigned coordinates.
   function automatic logic signed [W:0] sub_u(input logic [W-1:0] a, input logic [W-1:0] b);
      return $signed({1'b0, a}) - $signed({1'b0, b});
   endfunction

   // Partner vertex: i+1 while sorting, (i+1) mod N while evaluating.
   assign w_j    = (r_idx == c_AW'(N-1)) ? '0 : r_idx + c_AW'(1);
   assign w_sort = (r_state == S_SORT_A) || (r_state == S_SORT_B) || (r_state == S_SORT_J);

   always_comb begin
      w_da1 = '0;
      w_db1 = '0;
      w_da2 = '0;
      w_db2 = '0;
      if (w_sort) begin
         // s = (xi-x0)(yj-y0) - (xj-x0)(yi-y0)
         w_da1 = sub_u(r_vx[r_idx], r_vx[0]);
         w_db1 = sub_u(r_vy[w_j],   r_vy[0]);
         w_da2 = sub_u(r_vx[w_j],   r_vx[0]);
         w_db2 = sub_u(r_vy[r_idx], r_vy[0]);
      end else begin
         // c = (xj-xi)(py-yi) - (yj-yi)(px-xi)
         w_da1 = sub_u(r_vx[w_j], r_vx[r_idx]);
         w_db1 = sub_u(r_py,      r_vy[r_idx]);
         w_da2 = sub_u(r_vy[w_j], r_vy[r_idx]);
         w_db2 = sub_u(r_px,      r_vx[r_idx]);
      end
   end

   // Sign-extend operands to product width so the multiply is exact.
   assign w_dae  = {{(W+1){r_da[W]}}, r_da};
   assign w_dbe  = {{(W+1){r_db[W]}}, r_db};
   assign w_prod = $signed(w_dae) * $signed(w_dbe);
   assign w_diff = $signed({r_p1[c_PW-1], r_p1}) - $signed({w_prod[c_PW-1], w_prod});

   // Pass p compares i = 1..N-2-p, so the pass ends when i + p == N-2.
   assign w_pass_end = ((r_idx + r_pass) == c_AW'(N-2));
   assign w_last_cmp = w_pass_end && (r_pass == c_AW'(N-3));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_px     <= '0;
         r_py     <= '0;
         for (int k = 0; k < N; k++) begin
            r_vx[k] <= '0;
            r_vy[k] <= '0;
         end
         r_cnt    <= '0;
         r_idx    <= '0;
         r_pass   <= '0;
         r_neg    <= 1'b0;
         r_zero   <= 1'b0;
         r_ready  <= 1'b1;
         r_valid  <= 1'b0;
         r_inside <= 1'b0;
         r_edge   <= 1'b0;
         r_da     <= '0;
         r_db     <= '0;
         r_p1     <= '0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // in_ready stays low through the valid cycle and rises after it.
               if (!r_ready) begin
                  r_ready <= 1'b1;
               end else if (in_valid) begin
                  r_px    <= X;
                  r_py    <= Y;
                  r_cnt   <= '0;
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (in_valid) begin
                  r_vx[r_cnt] <= X;
                  r_vy[r_cnt] <= Y;
                  if (r_cnt == c_AW'(N-1)) begin
                     r_ready <= 1'b0;
                     r_idx   <= c_AW'(1);
                     r_pass  <= '0;
                     r_neg   <= 1'b0;
                     r_zero  <= 1'b0;
                     r_state <= S_SORT_A;
                  end else begin
                     r_cnt <= r_cnt + c_AW'(1);
                  end
               end
            end
            S_SORT_A, S_EVAL_A: begin
               r_da    <= w_da1;
               r_db    <= w_db1;
               r_state <= (r_state == S_SORT_A) ? S_SORT_B : S_EVAL_B;
            end
            S_SORT_B, S_EVAL_B: begin
               r_p1    <= w_prod;
               r_da    <= w_da2;
               r_db    <= w_db2;
               r_state <= (r_state == S_SORT_B) ? S_SORT_J : S_EVAL_J;
            end
            S_SORT_J: begin
               // Negative cross term: v(i+1) is clockwise of vi, so swap.
               if (w_diff[c_PW]) begin
                  r_vx[r_idx] <= r_vx[w_j];
                  r_vy[r_idx] <= r_vy[w_j];
                  r_vx[w_j]   <= r_vx[r_idx];
                  r_vy[w_j]   <= r_vy[r_idx];
               end
               if (w_last_cmp) begin
                  r_idx   <= '0;
                  r_state <= S_EVAL_A;
               end else if (w_pass_end) begin
                  r_pass  <= r_pass + c_AW'(1);
                  r_idx   <= c_AW'(1);
                  r_state <= S_SORT_A;
               end else begin
                  r_idx   <= r_idx + c_AW'(1);
                  r_state <= S_SORT_A;
               end
            end
            S_EVAL_J: begin
               r_neg  <= r_neg  | w_diff[c_PW];
               r_zero <= r_zero | (w_diff == '0);
               if (r_idx == c_AW'(N-1)) begin
                  r_state <= S_DONE;
               end else begin
                  r_idx   <= r_idx + c_AW'(1);
                  r_state <= S_EVAL_A;
               end
            end
            S_DONE: begin
               r_valid  <= 1'b1;
               r_inside <= !r_neg && (!r_zero || (EDGE_INSIDE != 0));
               r_edge   <= !r_neg && r_zero;
               r_state  <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = r_ready;
   assign valid     = r_valid;
   assign is_inside = r_inside;
   assign on_edge   = r_edge;

endmodule
`default_nettype wire

// File: tb/tb_geofence_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_geofence_n
// Description : Directed self-checking bench for geofence_n. Four instances
//               cover the hexagon (both edge policies), the full-range
//               square and the minimum triangle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_geofence_n;
   localparam int W = 10;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] X, Y;
   logic [3:0]   iv;
   logic [3:0]   rdy, vld, ins, edg;
   int           n_cmp = 0;
   int           n_bad = 0;
   int           vx_t [8];
   int           vy_t [8];

   always #5 clk = ~clk;

   geofence_n #(.W(W), .N(6), .EDGE_INSIDE(1)) u_hex (
      .clk(clk), .reset(rst_n), .X(X), .Y(Y), .in_valid(iv[0]),
      .in_ready(rdy[0]), .valid(vld[0]), .is_inside(ins[0]), .on_edge(edg[0]));
   geofence_n #(.W(W), .N(6), .EDGE_INSIDE(0)) u_hex0 (
      .clk(clk), .reset(rst_n), .X(X), .Y(Y), .in_valid(iv[1]),
      .in_ready(rdy[1]), .valid(vld[1]), .is_inside(ins[1]), .on_edge(edg[1]));
   geofence_n #(.W(W), .N(4), .EDGE_INSIDE(1)) u_sq (
      .clk(clk), .reset(rst_n), .X(X), .Y(Y), .in_valid(iv[2]),
      .in_ready(rdy[2]), .valid(vld[2]), .is_inside(ins[2]), .on_edge(edg[2]));
   geofence_n #(.W(W), .N(3), .EDGE_INSIDE(1)) u_tri (
      .clk(clk), .reset(rst_n), .X(X), .Y(Y), .in_valid(iv[3]),
      .in_ready(rdy[3]), .valid(vld[3]), .is_inside(ins[3]), .on_edge(edg[3]));

   task automatic load_hex();
      vx_t[0] = 0;  vy_t[0] = 5;
      vx_t[1] = 7;  vy_t[1] = 10;
      vx_t[2] = 3;  vy_t[2] = 0;
      vx_t[3] = 10; vy_t[3] = 5;
      vx_t[4] = 3;  vy_t[4] = 10;
      vx_t[5] = 7;  vy_t[5] = 0;
   endtask

   task automatic load_sq();
      vx_t[0] = 0;    vy_t[0] = 0;
      vx_t[1] = 1023; vy_t[1] = 0;
      vx_t[2] = 1023; vy_t[2] = 1023;
      vx_t[3] = 0;    vy_t[3] = 1023;
   endtask

   task automatic load_tri();
      vx_t[0] = 8; vy_t[0] = 0;
      vx_t[1] = 0; vy_t[1] = 0;
      vx_t[2] = 0; vy_t[2] = 8;
   endtask

   // Drive P then n vertices; p_wait counts negedges until P was accepted.
   task automatic send_coords(input int sel, input int n, input int px, input int py,
                              input bit gaps, output int p_wait);
      int k;
      int guard;
      int cx;
      int cy;
      k = 0; guard = 0; p_wait = 0;
      while (k < n + 1 && guard < 400) begin
         @(negedge clk);
         guard++;
         if (k == 0) p_wait++;
         if (gaps && k > 0 && $urandom_range(0, 2) == 0) begin
            iv[sel] = 1'b0;
         end else begin
            cx = (k == 0) ? px : vx_t[k-1];
            cy = (k == 0) ? py : vy_t[k-1];
            X = cx[W-1:0];
            Y = cy[W-1:0];
            iv[sel] = 1'b1;
            if (rdy[sel]) k++;
         end
      end
      if (k < n + 1) begin
         n_cmp++; n_bad++;
         $display("FAIL load_timeout: transferred %0d required %0d", k, n + 1);
      end
   endtask

   // lat counts cycles from the last vertex transfer edge to valid.
   task automatic wait_result(input int sel, input bit hold, output int lat, output bit got,
                              output logic r_in, output logic r_edge, output bit rleak);
      @(negedge clk);
      if (hold) begin
         X = '1; Y = '1;
      end else begin
         iv[sel] = 1'b0;
      end
      lat = 0; got = 1'b0; rleak = 1'b0;
      while (!got && lat < 300) begin
         if (rdy[sel]) rleak = 1'b1;
         @(negedge clk);
         lat++;
         if (vld[sel]) got = 1'b1;
      end
      iv[sel] = 1'b0;
      r_in   = ins[sel];
      r_edge = edg[sel];
   endtask

   task automatic test_reset();
      rst_n = 1'b0; iv = '0; X = '0; Y = '0;
      repeat (3) @(negedge clk);
      n_cmp++; if (rdy !== 4'hF) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1111", rdy); end
      n_cmp++; if (vld !== 4'h0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0000", vld); end
      n_cmp++; if (ins !== 4'h0) begin n_bad++; $display("FAIL reset_is_inside: got %b expected 0000", ins); end
      n_cmp++; if (edg !== 4'h0) begin n_bad++; $display("FAIL reset_on_edge: got %b expected 0000", edg); end
      rst_n = 1'b1;
   endtask

   task automatic test_basic_inside();
      int lat, pw; bit got, rl; logic ri, re;
      load_hex();
      send_coords(0, 6, 5, 5, 1'b0, pw);
      wait_result(0, 1'b0, lat, got, ri, re, rl);
      n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL basic_valid_seen: got %0d expected 1", got); end
      n_cmp++; if (lat !== 49) begin n_bad++; $display("FAIL basic_latency: got %0d expected 49", lat); end
      n_cmp++; if (ri !== 1'b1) begin n_bad++; $display("FAIL basic_is_inside: got %b expected 1", ri); end
      n_cmp++; if (re !== 1'b0) begin n_bad++; $display("FAIL basic_on_edge: got %b expected 0", re); end
      n_cmp++; if (rdy[0] !== 1'b0) begin n_bad++; $display("FAIL basic_ready_in_valid_cycle: got %b expected 0", rdy[0]); end
      @(negedge clk);
      n_cmp++; if (vld[0] !== 1'b0) begin n_bad++; $display("FAIL basic_single_pulse: got %b expected 0", vld[0]); end
      n_cmp++; if (rdy[0] !== 1'b1) begin n_bad++; $display("FAIL basic_ready_return: got %b expected 1", rdy[0]); end
      n_cmp++; if (ins[0] !== 1'b1) begin n_bad++; $display("FAIL basic_result_hold: got %b expected 1", ins[0]); end
   endtask

   task automatic test_outside_edge();
      int lat, pw; bit got, rl; logic ri, re;
      load_hex();
      send_coords(0, 6, 12, 5, 1'b0, pw);
      wait_result(0, 1'b0, lat, got, ri, re, rl);
      n_cmp++; if (ri !== 1'b0 || re !== 1'b0) begin n_bad++; $display("FAIL outside_12_5: got in=%b edge=%b expected in=0 edge=0", ri, re); end
      send_coords(0, 6, 5, 0, 1'b0, pw);
      wait_result(0, 1'b0, lat, got, ri, re, rl);
      n_cmp++; if (ri !== 1'b1 || re !== 1'b1) begin n_bad++; $display("FAIL edge_5_0_incl: got in=%b edge=%b expected in=1 edge=1", ri, re); end
      send_coords(1, 6, 5, 0, 1'b0, pw);
      wait_result(1, 1'b0, lat, got, ri, re, rl);
      n_cmp++; if (lat !== 49) begin n_bad++; $display("FAIL edge_excl_latency: got %0d expected 49", lat); end
      n_cmp++; if (ri !== 1'b0 || re !== 1'b1) begin n_bad++; $display("FAIL edge_5_0_excl: got in=%b edge=%b expected in=0 edge=1", ri, re); end
      send_coords(0, 6, 10, 5, 1'b0, pw);
      wait_result(0, 1'b0, lat, got, ri, re, rl);
      n_cmp++; if (ri !== 1'b1 || re !== 1'b1) begin n_bad++; $display("FAIL vertex_10_5: got in=%b edge=%b expected in=1 edge=1", ri, re); end
   endtask

   task automatic test_full_range();
      int lat, pw; bit got, rl; logic ri, re;
      load_sq();
      send_coords(2, 4, 1023, 512, 1'b0, pw);
      wait_result(2, 1'b0, lat, got, ri, re, rl);
      n_cmp++; if (lat !== 22) begin n_bad++; $display("FAIL square_latency: got %0d expected 22", lat); end
      n_cmp++; if (ri !== 1'b1 || re !== 1'b1) begin n_bad++; $display("FAIL square_edge: got in=%b edge=%b expected in=1 edge=1", ri, re); end
      send_coords(2, 4, 512, 512, 1'b0, pw);
      wait_result(2, 1'b0, lat, got, ri, re, rl);
      n_cmp++; if (ri !== 1'b1 || re !== 1'b0) begin n_bad++; $display("FAIL square_center: got in=%b edge=%b expected in=1 edge=0", ri, re); end
   endtask

   task automatic test_gaps();
      int lat, pw; bit got, rl; logic ri, re;
      load_hex();
      send_coords(0, 6, 5, 5, 1'b1, pw);
      wait_result(0, 1'b0, lat, got, ri, re, rl);
      n_cmp++; if (lat !== 49) begin n_bad++; $display("FAIL gaps_latency: got %0d expected 49", lat); end
      n_cmp++; if (ri !== 1'b1 || re !== 1'b0) begin n_bad++; $display("FAIL gaps_result: got in=%b edge=%b expected in=1 edge=0", ri, re); end
   endtask

   task automatic test_hold_valid();
      int lat, pw; bit got, rl; logic ri, re;
      load_hex();
      send_coords(0, 6, 12, 5, 1'b0, pw);
      wait_result(0, 1'b1, lat, got, ri, re, rl);
      n_cmp++; if (rl !== 1'b0) begin n_bad++; $display("FAIL hold_ready_low: got leak=%b expected 0", rl); end
      n_cmp++; if (lat !== 49) begin n_bad++; $display("FAIL hold_latency: got %0d expected 49", lat); end
      n_cmp++; if (ri !== 1'b0 || re !== 1'b0) begin n_bad++; $display("FAIL hold_result: got in=%b edge=%b expected in=0 edge=0", ri, re); end
      send_coords(0, 6, 5, 5, 1'b0, pw);
      wait_result(0, 1'b0, lat, got, ri, re, rl);
      n_cmp++; if (ri !== 1'b1 || re !== 1'b0) begin n_bad++; $display("FAIL hold_next_fence: got in=%b edge=%b expected in=1 edge=0", ri, re); end
   endtask

   task automatic test_back_to_back();
      int lat, pw; bit got, rl; logic ri, re;
      load_hex();
      send_coords(0, 6, 5, 0, 1'b0, pw);
      wait_result(0, 1'b0, lat, got, ri, re, rl);
      n_cmp++; if (ri !== 1'b1 || re !== 1'b1) begin n_bad++; $display("FAIL b2b_first: got in=%b edge=%b expected in=1 edge=1", ri, re); end
      send_coords(0, 6, 5, 5, 1'b0, pw);
      n_cmp++; if (pw !== 1) begin n_bad++; $display("FAIL b2b_p_accept: got wait=%0d expected 1", pw); end
      wait_result(0, 1'b0, lat, got, ri, re, rl);
      n_cmp++; if (lat !== 49) begin n_bad++; $display("FAIL b2b_latency: got %0d expected 49", lat); end
      n_cmp++; if (ri !== 1'b1 || re !== 1'b0) begin n_bad++; $display("FAIL b2b_second: got in=%b edge=%b expected in=1 edge=0", ri, re); end
   endtask

   task automatic test_reset_mid();
      int lat, pw; bit got, rl; logic ri, re;
      bit seen;
      load_hex();
      send_coords(0, 6, 5, 0, 1'b0, pw);
      @(negedge clk);
      iv[0] = 1'b0;           // state is SORT_A here
      @(negedge clk);         // state is SORT_B here
      rst_n = 1'b0;
      #1;
      n_cmp++; if (rdy[0] !== 1'b1) begin n_bad++; $display("FAIL midrst_in_ready: got %b expected 1", rdy[0]); end
      n_cmp++; if (vld[0] !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b expected 0", vld[0]); end
      n_cmp++; if (ins[0] !== 1'b0) begin n_bad++; $display("FAIL midrst_is_inside: got %b expected 0", ins[0]); end
      n_cmp++; if (edg[0] !== 1'b0) begin n_bad++; $display("FAIL midrst_on_edge: got %b expected 0", edg[0]); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (vld[0]) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midrst_no_valid: got %b expected 0", seen); end
      send_coords(0, 6, 5, 5, 1'b0, pw);
      wait_result(0, 1'b0, lat, got, ri, re, rl);
      n_cmp++; if (lat !== 49) begin n_bad++; $display("FAIL midrst_latency: got %0d expected 49", lat); end
      n_cmp++; if (ri !== 1'b1 || re !== 1'b0) begin n_bad++; $display("FAIL midrst_result: got in=%b edge=%b expected in=1 edge=0", ri, re); end
   endtask

   task automatic test_triangle();
      int lat, pw; bit got, rl; logic ri, re;
      load_tri();
      send_coords(3, 3, 2, 2, 1'b0, pw);
      wait_result(3, 1'b0, lat, got, ri, re, rl);
      n_cmp++; if (lat !== 13) begin n_bad++; $display("FAIL tri_latency: got %0d expected 13", lat); end
      n_cmp++; if (ri !== 1'b1 || re !== 1'b0) begin n_bad++; $display("FAIL tri_inside: got in=%b edge=%b expected in=1 edge=0", ri, re); end
      send_coords(3, 3, 5, 5, 1'b0, pw);
      wait_result(3, 1'b0, lat, got, ri, re, rl);
      n_cmp++; if (ri !== 1'b0 || re !== 1'b0) begin n_bad++; $display("FAIL tri_outside: got in=%b edge=%b expected in=0 edge=0", ri, re); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic_inside();
      test_outside_edge();
      test_full_range();
      test_gaps();
      test_hold_valid();
      test_back_to_back();
      test_reset_mid();
      test_triangle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
